// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU constants and fetch-state encoding
// used by the instruction fetch front end.
package instruction_fetch_unit_pkg;

    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 32;
    localparam int ADDR_STEP = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Prefetch queue: synchronous FIFO with flush,
// head word forced to zero while empty.
module fetch_queue #(
    parameter int WIDTH = 52,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign full  = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout  = empty ? '0 : mem[rd_ptr];

    // Upstream space accounting must make these impossible
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: one outstanding memory read,
// prefetch queue, redirect with response drain.
module instruction_fetch_unit #(
    parameter int ADDR_W    = instruction_fetch_unit_pkg::ADDR_W,
    parameter int DATA_W    = instruction_fetch_unit_pkg::DATA_W,
    parameter int QDEPTH    = 4,
    parameter int ADDR_STEP = instruction_fetch_unit_pkg::ADDR_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] instruction_address,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ready
);

    import instruction_fetch_unit_pkg::*;

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QMAX = CW'(QDEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    fetch_state_t state, state_next;
    logic [ADDR_W-1:0]        fetch_pc, pc_next;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [CW-1:0]            count;
    logic push, pop, flush, full, empty, pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= pc_next;
        end
    end

    // A response is still owed if accepted now or earlier and not yet returned
    assign pending = (state == REQ && mem_req_ready) ||
                     ((state == WAIT || state == DRAIN) && !mem_rsp_valid);
    assign pop = instr_valid && instr_ready && !redirect;

    always_comb begin
        state_next = state;
        pc_next    = fetch_pc;
        push       = 1'b0;
        flush      = redirect;
        unique case (state)
            IDLE: if (fetch_en && !full) state_next = REQ;
            REQ:  if (mem_req_ready) state_next = WAIT;
            WAIT: if (mem_rsp_valid) begin
                push       = 1'b1;
                pc_next    = fetch_pc + STEP;
                state_next = (fetch_en && (count + CW'(1) - CW'(pop)) < QMAX)
                             ? REQ : IDLE;
            end
            DRAIN: if (mem_rsp_valid) state_next = fetch_en ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            push       = 1'b0;
            pc_next    = instruction_address;
            state_next = pending ? DRAIN : (fetch_en ? REQ : IDLE);
        end
    end

    fetch_queue #(
        .WIDTH(ADDR_W + DATA_W),
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({fetch_pc, mem_rsp_data}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign mem_req_valid = state == REQ;
    assign mem_req_addr  = mem_req_valid ? fetch_pc : '0;
    assign instr_valid   = !empty;
    assign {instr_addr, instr_data} = head;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a
// variable-latency single-outstanding memory model.
module tb_instruction_fetch_unit;

    import instruction_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, fetch_en, redirect;
    logic [19:0] instruction_address;
    logic        mem_req_valid, mem_req_ready;
    logic [19:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data;
    logic [19:0] instr_addr;

    int total = 0;
    int bad = 0;
    int lat = 1;
    int pcnt = 0;
    logic [19:0] paddr;
    logic [19:0] req_log[$];
    logic [19:0] got_addr[$];
    logic [31:0] got_data[$];

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fetch_en            (fetch_en),
        .redirect            (redirect),
        .instruction_address (instruction_address),
        .mem_req_valid       (mem_req_valid),
        .mem_req_addr        (mem_req_addr),
        .mem_req_ready       (mem_req_ready),
        .mem_rsp_valid       (mem_rsp_valid),
        .mem_rsp_data        (mem_rsp_data),
        .instr_valid         (instr_valid),
        .instr_data          (instr_data),
        .instr_addr          (instr_addr),
        .instr_ready         (instr_ready)
    );

    function automatic logic [31:0] word(input logic [19:0] a);
        return {12'hA5C, a};
    endfunction

    // Memory: accepts at the edge, answers lat cycles later
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        paddr         = '0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pcnt = 0;
            end else begin
                if (pcnt > 0) begin
                    pcnt--;
                    if (pcnt == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = word(paddr);
                    end
                end
                if (mem_req_valid && mem_req_ready) begin
                    pcnt  = lat;
                    paddr = mem_req_addr;
                    req_log.push_back(mem_req_addr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en = 1'b0;
        redirect = 1'b0;
        instruction_address = '0;
        instr_ready = 1'b0;
        mem_req_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        req_log.delete();
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic do_redirect(input logic [19:0] a);
        redirect = 1'b1;
        instruction_address = a;
        fetch_en = 1'b1;
        tick();
        redirect = 1'b0;
    endtask

    task automatic collect(input int n);
        int cyc;
        cyc = 0;
        while (got_addr.size() < n && cyc < 200) begin
            if (instr_valid && instr_ready) begin
                got_addr.push_back(instr_addr);
                got_data.push_back(instr_data);
            end
            if (got_addr.size() < n) tick();
            cyc++;
        end
        if (got_addr.size() < n) begin
            total++; bad++;
            $display("FAIL collect_timeout got=%0d need=%0d", got_addr.size(), n);
        end
    endtask

    task automatic wait_req(input logic [19:0] a);
        int cyc;
        cyc = 0;
        while (!(mem_req_valid && mem_req_addr == a) && cyc < 60) begin
            tick();
            cyc++;
        end
        if (!(mem_req_valid && mem_req_addr == a)) begin
            total++; bad++;
            $display("FAIL wait_req_timeout addr=%h", a);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", mem_req_valid); end
        total++; if (mem_req_addr !== 20'h0) begin bad++; $display("FAIL rst_req_addr got=%h exp=0", mem_req_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
        total++; if (instr_data !== 32'h0) begin bad++; $display("FAIL rst_instr_data got=%h exp=0", instr_data); end
        total++; if (instr_addr !== 20'h0) begin bad++; $display("FAIL rst_instr_addr got=%h exp=0", instr_addr); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dut.state, IDLE); end
        total++; if (dut.u_queue.count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", dut.u_queue.count); end
        repeat (3) tick();
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b exp=0", mem_req_valid); end
    endtask

    task automatic test_sequence();
        do_reset();
        lat = 1;
        instr_ready = 1'b1;
        do_redirect(20'h01000);
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL seq_req_lat got=%b exp=1", mem_req_valid); end
        total++; if (mem_req_addr !== 20'h01000) begin bad++; $display("FAIL seq_req_addr got=%h exp=01000", mem_req_addr); end
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_early_valid got=%b exp=0", instr_valid); end
        tick();
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_rsp_lat got=%b exp=1", instr_valid); end
        collect(4);
        for (int i = 0; i < got_addr.size(); i++) begin
            total++; if (got_addr[i] !== 20'h01000 + 20'(4 * i)) begin bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, got_addr[i], 20'h01000 + 20'(4 * i)); end
            total++; if (got_data[i] !== word(20'h01000 + 20'(4 * i))) begin bad++; $display("FAIL seq_data%0d got=%h", i, got_data[i]); end
        end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            total++; if (req_log[i] !== 20'h01000 + 20'(4 * i)) begin bad++; $display("FAIL seq_req%0d got=%h exp=%h", i, req_log[i], 20'h01000 + 20'(4 * i)); end
        end
    endtask

    task automatic test_full();
        do_reset();
        lat = 1;
        instr_ready = 1'b0;
        do_redirect(20'h01000);
        repeat (20) tick();
        total++; if (dut.u_queue.count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", dut.u_queue.count); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL full_req_valid got=%b exp=0", mem_req_valid); end
        total++; if (req_log.size() !== 4) begin bad++; $display("FAIL full_nreq got=%0d exp=4", req_log.size()); end
        total++; if (instr_addr !== 20'h01000) begin bad++; $display("FAIL full_head got=%h exp=01000", instr_addr); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        total++; if (instr_addr !== 20'h01004) begin bad++; $display("FAIL full_pop_head got=%h exp=01004", instr_addr); end
        wait_req(20'h01010);
        repeat (10) tick();
        total++; if (req_log.size() !== 5) begin bad++; $display("FAIL full_one_more got=%0d exp=5", req_log.size()); end
        total++; if (dut.u_queue.count !== 3'd4) begin bad++; $display("FAIL full_refill got=%0d exp=4", dut.u_queue.count); end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        lat = 3;
        instr_ready = 1'b0;
        do_redirect(20'h01000);
        wait_req(20'h01004);
        tick();
        redirect = 1'b1;
        instruction_address = 20'h20000;
        instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL drn_flush got=%b exp=0", instr_valid); end
        total++; if (dut.state !== DRAIN) begin bad++; $display("FAIL drn_state got=%0d exp=%0d", dut.state, DRAIN); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL drn_req got=%b exp=0", mem_req_valid); end
        collect(1);
        if (got_addr.size() > 0) begin
            total++; if (got_addr[0] !== 20'h20000) begin bad++; $display("FAIL drn_first_addr got=%h exp=20000", got_addr[0]); end
            total++; if (got_data[0] !== word(20'h20000)) begin bad++; $display("FAIL drn_first_data got=%h", got_data[0]); end
        end
        if (req_log.size() > 2) begin
            total++; if (req_log[2] !== 20'h20000) begin bad++; $display("FAIL drn_reissue got=%h exp=20000", req_log[2]); end
        end
    endtask

    task automatic test_wrap();
        logic [19:0] exp_a [3];
        exp_a = '{20'hFFFF8, 20'hFFFFC, 20'h00000};
        do_reset();
        lat = 1;
        instr_ready = 1'b1;
        do_redirect(20'hFFFF8);
        collect(3);
        for (int i = 0; i < got_addr.size(); i++) begin
            total++; if (got_addr[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, got_addr[i], exp_a[i]); end
            total++; if (got_data[i] !== word(exp_a[i])) begin bad++; $display("FAIL wrap_data%0d got=%h", i, got_data[i]); end
        end
    endtask

    task automatic test_fetch_en_off();
        do_reset();
        lat = 3;
        instr_ready = 1'b0;
        do_redirect(20'h01000);
        fetch_en = 1'b0;
        repeat (8) tick();
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL fen_kept got=%b exp=1", instr_valid); end
        total++; if (instr_addr !== 20'h01000) begin bad++; $display("FAIL fen_addr got=%h exp=01000", instr_addr); end
        total++; if (instr_data !== word(20'h01000)) begin bad++; $display("FAIL fen_data got=%h", instr_data); end
        total++; if (req_log.size() !== 1) begin bad++; $display("FAIL fen_nreq got=%0d exp=1", req_log.size()); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL fen_state got=%0d exp=%0d", dut.state, IDLE); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        lat = 3;
        instr_ready = 1'b0;
        do_redirect(20'h01000);
        wait_req(20'h01008);
        tick();
        total++; if (dut.u_queue.count !== 3'd2) begin bad++; $display("FAIL rmw_pre_count got=%0d exp=2", dut.u_queue.count); end
        rst_n = 1'b0;
        fetch_en = 1'b0;
        tick();
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rmw_req_valid got=%b exp=0", mem_req_valid); end
        total++; if (mem_req_addr !== 20'h0) begin bad++; $display("FAIL rmw_req_addr got=%h exp=0", mem_req_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmw_valid got=%b exp=0", instr_valid); end
        total++; if (instr_data !== 32'h0) begin bad++; $display("FAIL rmw_data got=%h exp=0", instr_data); end
        total++; if (instr_addr !== 20'h0) begin bad++; $display("FAIL rmw_addr got=%h exp=0", instr_addr); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rmw_state got=%0d exp=%0d", dut.state, IDLE); end
        total++; if (dut.u_queue.count !== 3'd0) begin bad++; $display("FAIL rmw_count got=%0d exp=0", dut.u_queue.count); end
        rst_n = 1'b1;
        repeat (6) tick();
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rmw_no_drain got=%0d exp=%0d", dut.state, IDLE); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmw_no_push got=%b exp=0", instr_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_en = 1'b0;
        redirect = 1'b0;
        instruction_address = '0;
        instr_ready = 1'b0;
        mem_req_ready = 1'b1;
        test_reset();
        test_sequence();
        test_full();
        test_redirect_drain();
        test_wrap();
        test_fetch_en_off();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
